key_event_encoder: RTL and testbench



---
 rtl/key_pkg.sv | 54 +++++
 rtl/key_event_encoder_if.sv | 23 ++
 rtl/key_fifo.sv | 72 +++++++
 rtl/key_event_encoder.sv | 143 ++++++++++++++
 tb/tb_key_event_encoder.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the keypad event encoder: key codes, FSM states, raw-to-code map.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package key_pkg;

    typedef logic [3:0] key_code_t;

    localparam key_code_t KEY_0   = 4'h0;
    localparam key_code_t KEY_1   = 4'h1;
    localparam key_code_t KEY_2   = 4'h2;
    localparam key_code_t KEY_3   = 4'h3;
    localparam key_code_t KEY_4   = 4'h4;
    localparam key_code_t KEY_5   = 4'h5;
    localparam key_code_t KEY_6   = 4'h6;
    localparam key_code_t KEY_7   = 4'h7;
    localparam key_code_t KEY_8   = 4'h8;
    localparam key_code_t KEY_9   = 4'h9;
    localparam key_code_t KEY_ADD = 4'hA;
    localparam key_code_t KEY_SUB = 4'hB;
    localparam key_code_t KEY_MUL = 4'hC;
    localparam key_code_t KEY_DIV = 4'hD;
    localparam key_code_t KEY_EQ  = 4'hE;
    localparam key_code_t KEY_CLR = 4'hF;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DEBOUNCE = 2'b01,
        PRESSED  = 2'b10,
        RELEASE  = 2'b11
    } state_t;

    // Raw keypad position {row, column} to calculator key code.
    function automatic key_code_t keymap(input logic [3:0] raw);
        case (raw)
            4'h0:    keymap = KEY_0;
            4'h1:    keymap = KEY_1;
            4'h2:    keymap = KEY_2;
            4'h3:    keymap = KEY_3;
            4'h4:    keymap = KEY_4;
            4'h5:    keymap = KEY_5;
            4'h6:    keymap = KEY_6;
            4'h7:    keymap = KEY_7;
            4'h8:    keymap = KEY_8;
            4'h9:    keymap = KEY_9;
            4'hA:    keymap = KEY_ADD;
            4'hB:    keymap = KEY_SUB;
            4'hC:    keymap = KEY_MUL;
            4'hD:    keymap = KEY_DIV;
            4'hE:    keymap = KEY_EQ;
            default: keymap = KEY_CLR;
        endcase
    endfunction

endpackage

// File: rtl/key_event_encoder_if.sv
// Key-event link from the encoder to the calculator FSM.
// Latency: none (wires only).
// Backpressure: consumer holds KEY_READY low to leave the head entry queued.
interface key_event_encoder_if;
    import key_pkg::*;

    key_code_t KEY_CODE;
    logic      KEY_VALID;
    logic      KEY_READY;
    logic      OVERFLOW;
    logic      CLR_OVF;
    logic      KEY_HELD;

    modport master (
        output KEY_CODE, KEY_VALID, OVERFLOW, KEY_HELD,
        input  KEY_READY, CLR_OVF
    );

    modport slave (
        input  KEY_CODE, KEY_VALID, OVERFLOW, KEY_HELD,
        output KEY_READY, CLR_OVF
    );
endinterface

// File: rtl/key_fifo.sv
// Circular key-code queue with a registered head entry (zero when empty).
// Latency: a push is visible at the head output one cycle later.
// Backpressure: a push while full is dropped (ovf_set_o) unless a pop frees a slot that cycle.
module key_fifo
    import key_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  key_code_t push_dat_i,
    input  logic      pop_i,
    output key_code_t head_o,
    output logic      empty_o,
    output logic      full_o,
    output logic      ovf_set_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    key_code_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    key_code_t        head_q, head_d;
    logic             pop_ok, push_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == DEPTH_C);
    assign pop_ok    = pop_i & ~empty_o;
    assign push_ok   = push_i & (~full_o | pop_ok);
    assign ovf_set_o = push_i & full_o & ~pop_ok;
    assign head_o    = head_q;

    // Pointer/count update and next head; a push into a queue that is empty
    // after this cycle's pop becomes the head directly.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        count_d  = count_q + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop_ok);
        head_d   = mem_q[rd_ptr_d];
        if (count_d == '0) begin
            head_d = KEY_0;
        end else if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_dat_i;
        end
    end

    // Control state; storage contents need no reset since count gates them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= KEY_0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/key_event_encoder.sv
// Synchronises and debounces keypad lines, encodes each press and queues it for the calculator.
// Latency: push DEBOUNCE_CYCLES cycles after the synchronised key-detect (2 sync cycles earlier).
// Backpressure: KEY_READY low holds entries; presses arriving into a full queue set OVERFLOW.
module key_event_encoder
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_W           = 5
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       D0,
    input  logic                       D1,
    input  logic                       Q0,
    input  logic                       Q1,
    input  logic                       OUT,
    key_event_encoder_if.master        key_if
);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES);

    logic [4:0]       sync1_q, sync2_q;
    logic [3:0]       raw_s;
    logic             out_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic             ovf_q, ovf_d;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full_unused;
    logic             fifo_ovf_set;
    key_code_t        fifo_head;

    assign raw_s = sync2_q[4:1];
    assign out_s = sync2_q[0];

    // Two-flop synchronisers on {D1, D0, Q1, Q0, OUT}.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {D1, D0, Q1, Q0, OUT};
            sync2_q <= sync1_q;
        end
    end

    // Press/release debounce: one push per accepted press, raw changes while held ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (out_s) begin
                    cand_d  = raw_s;
                    cnt_d   = CNT_ONE;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!out_s) begin
                    state_d = IDLE;
                end else if (raw_s != cand_q) begin
                    cand_d = raw_s;
                    cnt_d  = CNT_ONE;
                end else if (cnt_q == DEB_LAST) begin
                    push    = 1'b1;
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!out_s) begin
                    cnt_d   = CNT_ONE;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (out_s) begin
                    state_d = PRESSED;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky overflow: a dropped press wins over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (fifo_ovf_set) begin
            ovf_d = 1'b1;
        end else if (key_if.CLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    // FSM, counter, candidate and overflow registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pop = ~fifo_empty & key_if.KEY_READY;

    key_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .push_i     (push),
        .push_dat_i (keymap(cand_q)),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full_unused),
        .ovf_set_o  (fifo_ovf_set)
    );

    assign key_if.KEY_CODE  = fifo_head;
    assign key_if.KEY_VALID = ~fifo_empty;
    assign key_if.OVERFLOW  = ovf_q;
    assign key_if.KEY_HELD  = (state_q == PRESSED) || (state_q == RELEASE);

endmodule

// File: tb/tb_key_event_encoder.sv
// Bench for key_event_encoder: directed scenarios with literal expectations plus random keypad
// activity, all checked every cycle against a run-length/queue model of the key-event rules.
module tb_key_event_encoder;
    localparam int DEB   = 4;
    localparam int DEPTH = 4;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b1;
    logic D0 = 1'b0, D1 = 1'b0, Q0 = 1'b0, Q1 = 1'b0, OUT = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    key_event_encoder_if kif ();

    key_event_encoder #(
        .DEBOUNCE_CYCLES (DEB),
        .FIFO_DEPTH      (DEPTH),
        .CNT_W           (5)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .D0      (D0),
        .D1      (D1),
        .Q0      (Q0),
        .Q1      (Q1),
        .OUT     (OUT),
        .key_if  (kif.master)
    );

    always #5 CLK = ~CLK;

    // Reference model: a press is accepted once OUT=1 with an unchanged position has been
    // seen for DEB+1 consecutive synchronised samples while no key is held; a held key is
    // released after DEB+1 consecutive OUT=0 samples. Accepted codes go into a queue.
    logic [4:0] m_s1 = '0, m_s2 = '0;
    int         run1 = 0, run0 = 0;
    logic [3:0] run_raw = '0;
    bit         held = 1'b0;
    bit         m_ovf = 1'b0;
    logic [3:0] mq[$];

    initial begin
        forever begin
            @(posedge CLK or negedge RESET_N);
            if (!RESET_N) begin
                m_s1 = '0; m_s2 = '0; run1 = 0; run0 = 0; run_raw = '0;
                held = 1'b0; m_ovf = 1'b0; mq.delete();
            end else begin
                bit push, do_pop, ovf_set;
                push = 1'b0; ovf_set = 1'b0;
                do_pop = (mq.size() != 0) && (kif.KEY_READY === 1'b1);
                if (!held) begin
                    if (m_s2[0]) begin
                        if (run1 > 0 && m_s2[4:1] == run_raw) run1++;
                        else begin run1 = 1; run_raw = m_s2[4:1]; end
                        if (run1 == DEB + 1) begin push = 1'b1; held = 1'b1; run0 = 0; end
                    end else run1 = 0;
                end else begin
                    if (!m_s2[0]) begin
                        run0++;
                        if (run0 == DEB + 1) begin held = 1'b0; run1 = 0; end
                    end else run0 = 0;
                end
                if (do_pop) void'(mq.pop_front());
                if (push) begin
                    if (mq.size() < DEPTH) mq.push_back(run_raw);
                    else ovf_set = 1'b1;
                end
                if (ovf_set) m_ovf = 1'b1;
                else if (kif.CLR_OVF === 1'b1) m_ovf = 1'b0;
                m_s2 = m_s1;
                m_s1 = {D1, D0, Q1, Q0, OUT};
            end
        end
    end

    // Per-cycle comparison of all outputs against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                n_tests++;
                if ({kif.KEY_CODE, kif.KEY_VALID, kif.OVERFLOW, kif.KEY_HELD} !==
                    {((mq.size() != 0) ? mq[0] : 4'h0), (mq.size() != 0), m_ovf, held}) begin
                    n_fail++;
                    $display("FAIL model_cmp t=%0t code/valid/ovf/held got %h/%b/%b/%b expected %h/%b/%b/%b",
                             $time, kif.KEY_CODE, kif.KEY_VALID, kif.OVERFLOW, kif.KEY_HELD,
                             ((mq.size() != 0) ? mq[0] : 4'h0), (mq.size() != 0), m_ovf, held);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic o);
        {D1, D0, Q1, Q0} = r;
        OUT = o;
    endtask

    task automatic press(input logic [3:0] r);
        drive(r, 1'b1);
        step(8);
        drive(r, 1'b0);
        step(9);
    endtask

    task automatic pop_one();
        kif.KEY_READY = 1'b1;
        step(1);
        kif.KEY_READY = 1'b0;
    endtask

    initial begin
        int lat;
        logic [3:0] exp5 [4];
        kif.KEY_READY = 1'b0;
        kif.CLR_OVF   = 1'b0;
        #1 RESET_N = 1'b0;
        #1 chk_en = 1'b1;
        check("reset_valid", 32'(kif.KEY_VALID), 0);
        check("reset_code", 32'(kif.KEY_CODE), 0);
        check("reset_held", 32'(kif.KEY_HELD), 0);
        step(3);
        RESET_N = 1'b1;
        step(2);

        // Clean press of position 7.
        drive(4'h7, 1'b1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (kif.KEY_VALID === 1'b1) begin lat = i; break; end
        end
        check("clean_latency", 32'(lat), 7);
        check("clean_code", 32'(kif.KEY_CODE), 32'h7);
        check("clean_held", 32'(kif.KEY_HELD), 1);
        step(3);
        drive(4'h7, 1'b0);
        step(9);
        check("clean_released", 32'(kif.KEY_HELD), 0);
        pop_one();
        check("clean_single_event", 32'(kif.KEY_VALID), 0);

        // Bouncy press ending on ADD.
        drive(4'hA, 1'b1); step(1);
        drive(4'hA, 1'b0); step(1);
        drive(4'hA, 1'b1); step(1);
        drive(4'hA, 1'b0); step(1);
        drive(4'hA, 1'b1); step(4);
        check("bounce_no_early_push", 32'(kif.KEY_VALID), 0);
        step(6);
        check("bounce_code", 32'(kif.KEY_CODE), 32'hA);
        drive(4'hA, 1'b0);
        step(9);
        pop_one();
        check("bounce_single_event", 32'(kif.KEY_VALID), 0);

        // Release with a bounce.
        drive(4'h3, 1'b1); step(8);
        drive(4'h3, 1'b0); step(2);
        drive(4'h3, 1'b1); step(1);
        drive(4'h3, 1'b0); step(6);
        check("relbounce_still_held", 32'(kif.KEY_HELD), 1);
        step(2);
        check("relbounce_released", 32'(kif.KEY_HELD), 0);
        check("relbounce_code", 32'(kif.KEY_CODE), 32'h3);
        pop_one();
        check("relbounce_single_event", 32'(kif.KEY_VALID), 0);

        // Overflow: five presses into a four-deep queue.
        for (int c = 1; c <= 5; c++) press(4'(c));
        check("ovf_set", 32'(kif.OVERFLOW), 1);
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain", 32'(kif.KEY_CODE), 32'(i + 1));
            pop_one();
        end
        check("ovf_drained_empty", 32'(kif.KEY_VALID), 0);
        check("ovf_sticky", 32'(kif.OVERFLOW), 1);
        kif.CLR_OVF = 1'b1;
        step(1);
        kif.CLR_OVF = 1'b0;
        check("ovf_cleared", 32'(kif.OVERFLOW), 0);

        // Push and pop in the same cycle while full.
        for (int c = 6; c <= 9; c++) press(4'(c));
        drive(4'hB, 1'b1);
        step(6);
        kif.KEY_READY = 1'b1;
        step(1);
        kif.KEY_READY = 1'b0;
        check("full_pushpop_no_ovf", 32'(kif.OVERFLOW), 0);
        drive(4'hB, 1'b0);
        step(9);
        exp5 = '{4'h7, 4'h8, 4'h9, 4'hB};
        for (int i = 0; i < 4; i++) begin
            check("full_pushpop_drain", 32'(kif.KEY_CODE), 32'(exp5[i]));
            pop_one();
        end
        check("full_pushpop_count", 32'(kif.KEY_VALID), 0);

        // Reset during debounce with two entries queued and overflow set.
        for (int c = 1; c <= 5; c++) press(4'(c));
        pop_one();
        pop_one();
        drive(4'h5, 1'b1);
        step(4);
        RESET_N = 1'b0;
        #1;
        check("rst_mid_valid", 32'(kif.KEY_VALID), 0);
        check("rst_mid_code", 32'(kif.KEY_CODE), 0);
        check("rst_mid_held", 32'(kif.KEY_HELD), 0);
        check("rst_mid_ovf", 32'(kif.OVERFLOW), 0);
        drive(4'h0, 1'b0);
        step(2);
        RESET_N = 1'b1;
        step(12);
        check("rst_no_event", 32'(kif.KEY_VALID), 0);

        // Random keypad activity, consumer stalls and overflow clears.
        for (int s = 0; s < 250; s++) begin
            logic [3:0] r;
            logic o;
            int len;
            r   = 4'($urandom % 16);
            o   = ($urandom % 3) != 0;
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) begin
                kif.KEY_READY = ($urandom % 4) == 0;
                kif.CLR_OVF   = ($urandom % 16) == 0;
                if (o && ($urandom % 10) == 0) drive(4'($urandom % 16), o);
                else drive(r, o);
                step(1);
            end
        end
        drive(4'h0, 1'b0);
        kif.CLR_OVF   = 1'b0;
        kif.KEY_READY = 1'b1;
        step(20);
        check("random_drained", 32'(kif.KEY_VALID), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
